timer_unit: RTL
===============

Name: timer_unit

Overview:
Parametrised multi-channel programmable timer for the Tiny16 system. It generalises the fixed single-bit timer tap used in main into CHANNELS independent down-counters. Each channel has a selectable prescaler tap, periodic or one-shot mode, and a per-channel interrupt flag. It sits on the CPU peripheral bus, and its irq output drives the CPU interrupt / WFI wake-up input.

Parameters:
CHANNELS, 2, number of timer channels (1..4).
COUNTER_BITS, 16, width of each down-counter and reload register (1..16).
PRESCALER_BITS, 8, width of the shared free-running prescaler (>= 8).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
sel  in  1  bus chip select
wr  in  1  bus write strobe; a write takes effect when sel & wr at a rising clk edge
addr  in  4  addr[3:2] = channel, addr[1:0] = register
data_in  in  16  write data
data_out  out  16  read data, combinational from addr
irq_vec  out  CHANNELS  per-channel pending & IE
irq  out  1  OR of irq_vec

Behaviour:
- Register map per channel:
  - 0 CTRL: bit0 EN, bit1 ONESHOT, bit2 IE, bits[6:4] DIV. Other bits read 0.
  - 1 RELOAD: COUNTER_BITS wide.
  - 2 COUNT: read-only; writes are ignored.
  - 3 STATUS: bit0 PENDING; write 1 to clear, write 0 has no effect.
- Upper data bits beyond a register's width read 0. A channel index >= CHANNELS reads 0 and ignores writes.
- Reset (async): prescaler, CTRL, RELOAD, COUNT and PENDING all go to 0. Hence data_out = 0 at addr 0, irq_vec = 0, irq = 0. A mid-operation reset aborts counting immediately, with no pending flag left set.
- Prescaler: free-running, increments every clk and wraps at 2^PRESCALER_BITS.
  - tick[k] = 1 when prescaler bits [k-1:0] are all ones; tick[0] = 1 every cycle.
  - A channel with DIV=k advances once per 2^k cycles.
- Channel update, at each edge where EN=1 and tick[DIV]=1:
  - COUNT != 0: COUNT <= COUNT - 1.
  - COUNT == 0: PENDING <= 1. In periodic mode COUNT <= RELOAD. In one-shot mode EN <= 0 and COUNT stays 0.
- Period is (RELOAD+1) ticks. RELOAD=0 with DIV=0 periodic sets PENDING on every enabled cycle.
- Writing RELOAD also loads COUNT with the same value at the same edge.
- EN=0 freezes COUNT; it does not clear it.
- Simultaneous events:
  - A bus write to RELOAD or CTRL in the same cycle as a tick: the write wins for the written register. No decrement is applied that cycle.
  - A STATUS clear in the same cycle as an expiry: set wins, so PENDING stays 1.
  - A one-shot expiry in the same cycle as a CTRL write setting EN=1: EN stays 1.
- irq_vec[i] = PENDING[i] & IE[i], combinational from registers. Latency from the expiry edge to irq is therefore 0 cycles after that edge. Clearing IE masks irq without clearing PENDING.
- Channels are fully independent and share only the prescaler.

Test Plan:
- Reset values: assert reset for 3 cycles -> all register reads return 0, irq=0. Assert reset mid-count (COUNT=5) -> COUNT=0 and EN=0 immediately, before the next clk edge.
- Periodic mode: ch0 RELOAD=3, then CTRL=0x05 (EN, IE, DIV=0) written at edge t -> COUNT reads 3,2,1,0 over the following edges. PENDING and irq go 1 at edge t+4, COUNT reloads to 3, and PENDING is set again at t+8.
- One-shot mode: ch1 RELOAD=2, CTRL=0x07 -> PENDING=1 at edge t+3, EN reads 0, COUNT stays 0 for 20 further cycles, irq_vec=2'b10.
- W1C and collision: clear STATUS while ch0 idles -> PENDING=0. Issue the clear write on the exact expiry edge -> PENDING remains 1. With IE=0 and PENDING=1 -> irq=0, and STATUS still reads 1.
- Prescaler scaling: ch0 DIV=2, RELOAD=1 -> COUNT changes only on edges where prescaler[1:0]=3, giving an expiry every 8 clk cycles. ch1 DIV=0 concurrently -> its own independent period is unaffected.
- Write precedence: write RELOAD=10 on a tick edge of a running channel -> COUNT=10 after that edge, with no decrement that cycle. A write to COUNT (reg 2) leaves COUNT unchanged.

Source files
------------

// File: rtl/timer_unit_if.sv
// Peripheral bus between the Tiny16 CPU and the timer: chip select, write strobe,
// register address, write data and combinational read data.
interface timer_unit_if;
    logic        sel;
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] data_in;
    logic [15:0] data_out;

    modport master (output sel, output wr, output addr, output data_in, input data_out);
    modport slave  (input sel, input wr, input addr, input data_in, output data_out);
endinterface

// File: rtl/timer_unit.sv
// Multi-channel down-counter timer: shared free-running prescaler, per-channel DIV tap,
// periodic/one-shot mode and pending flag. Reads are combinational, writes take one edge; never stalls the bus.
module timer_unit #(
    parameter int CHANNELS       = 2,
    parameter int COUNTER_BITS   = 16,
    parameter int PRESCALER_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    timer_unit_if.slave         bus,
    output logic [CHANNELS-1:0] irq_vec,
    output logic                irq
);
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_RELOAD = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [PRESCALER_BITS-1:0] presc;
    logic [7:0]                tick;

    logic [CHANNELS-1:0]     en, oneshot, ie, pending;
    logic [2:0]              div    [CHANNELS];
    logic [COUNTER_BITS-1:0] reload [CHANNELS];
    logic [COUNTER_BITS-1:0] count  [CHANNELS];

    logic [CHANNELS-1:0] hit_ctrl, hit_reload, hit_status, adv, expire;

    logic                    wr_stb;
    logic [1:0]              wr_ch, wr_reg;
    logic [COUNTER_BITS-1:0] wr_cnt;
    logic [15:0]             rdata;

    assign wr_stb = bus.sel & bus.wr;
    assign wr_ch  = bus.addr[3:2];
    assign wr_reg = bus.addr[1:0];
    assign wr_cnt = bus.data_in[COUNTER_BITS-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) presc <= '0;
        else       presc <= presc + 1'b1;
    end

    // tick[k] fires when the low k prescaler bits are all ones; tick[0] is always set
    always_comb begin
        tick = '0;
        for (int k = 0; k < 8; k++)
            tick[k] = &(presc[7:0] | ~((8'd1 << k) - 8'd1));
    end

    always_comb begin
        hit_ctrl   = '0;
        hit_reload = '0;
        hit_status = '0;
        adv        = '0;
        expire     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hit_ctrl[i]   = wr_stb && (wr_ch == 2'(i)) && (wr_reg == REG_CTRL);
            hit_reload[i] = wr_stb && (wr_ch == 2'(i)) && (wr_reg == REG_RELOAD);
            hit_status[i] = wr_stb && (wr_ch == 2'(i)) && (wr_reg == REG_STATUS);
            adv[i]        = en[i] && tick[div[i]];
            expire[i]     = adv[i] && (count[i] == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en      <= '0;
            oneshot <= '0;
            ie      <= '0;
            pending <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                div[i]    <= '0;
                reload[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // A CTRL write overrides the one-shot auto-disable for this edge
                if (hit_ctrl[i]) begin
                    en[i]      <= bus.data_in[0];
                    oneshot[i] <= bus.data_in[1];
                    ie[i]      <= bus.data_in[2];
                    div[i]     <= bus.data_in[6:4];
                end else if (expire[i] && oneshot[i]) begin
                    en[i] <= 1'b0;
                end

                // RELOAD/CTRL writes suppress the counter step of this edge
                if (hit_reload[i]) begin
                    reload[i] <= wr_cnt;
                    count[i]  <= wr_cnt;
                end else if (adv[i] && !hit_ctrl[i]) begin
                    if (expire[i]) count[i] <= oneshot[i] ? count[i] : reload[i];
                    else           count[i] <= count[i] - 1'b1;
                end

                if (expire[i])                              pending[i] <= 1'b1;
                else if (hit_status[i] && bus.data_in[0])   pending[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.addr[3:2] == 2'(i)) begin
                case (bus.addr[1:0])
                    REG_CTRL:   rdata = {9'b0, div[i], 1'b0, ie[i], oneshot[i], en[i]};
                    REG_RELOAD: rdata = 16'(reload[i]);
                    REG_COUNT:  rdata = 16'(count[i]);
                    REG_STATUS: rdata = {15'b0, pending[i]};
                    default:    rdata = '0;
                endcase
            end
        end
    end

    assign bus.data_out = rdata;
    assign irq_vec      = pending & ie;
    assign irq          = |irq_vec;
endmodule
